moore_seq_detector_param: RTL and testbench
===========================================

Name: moore_seq_detector_param

Overview:
Parametrised Moore serial-sequence detector, successor to the fixed-pattern overlapping detector. It compares a serial bit stream against an N-bit pattern and supports overlapping or non-overlapping detection. The pattern is set at elaboration and can be reloaded at run time. It also provides an input-valid qualifier and a saturating match counter. It sits in the sequential/FSM library as a drop-in framing/sync-word detector.

Parameters:
N, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1011, reset/default pattern, N bits wide; bit N-1 is the first bit received.
OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping (history is restarted after each match).
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  bit-valid; `in` is sampled only when en=1.
in  input  1  serial data bit.
pat_load  input  1  load strobe for a new pattern; soft restart.
pat_in  input  N  new pattern, sampled when pat_load=1.
clr_count  input  1  clears match_count and count_sat.
out  output  1  Moore match flag, registered.
match_count  output  CNT_W  number of matches, saturating.
count_sat  output  1  sticky flag; set when match_count reaches all-ones.

Behaviour:
- State registers:
  - pat_q[N-1:0]: active pattern.
  - hist[N-1:0]: last accepted bits, newest bit in hist[0].
  - fill: 0..N, count of valid history bits.
  - match_q: drives `out`.
  - match_count, count_sat.
- Reset (rst=1 at an edge), with highest priority:
  - pat_q=PATTERN, hist=0, fill=0.
  - out=0, match_count=0, count_sat=0.
  - Reset mid-sequence discards all partial history.
- pat_load=1 (priority over en):
  - pat_q<=pat_in; hist<=0; fill<=0; out<=0.
  - The `in` bit in that cycle is dropped.
  - match_count is kept.
- Accepted bit (en=1, no rst, no pat_load):
  - hist_n={hist[N-2:0],in}.
  - fill_n=min(fill+1,N).
  - hit=(fill_n==N)&&(hist_n==pat_q).
  - hist<=hist_n; match_q<=hit.
  - fill<=fill_n, except when hit and OVERLAP=0: then fill<=0, so a new match needs N fresh bits.
- Cycle with en=0: hist/fill hold; match_q<=0.
  - `out` is therefore a one-cycle pulse in the clock after the final pattern bit is accepted (latency 1 clock).
  - Gaps in en do not break a partial sequence.
- Overlap mode: back-to-back matches are possible when the pattern's suffix equals its prefix, e.g. all-ones pattern matches on every bit once fill=N.
- Counter:
  - On hit, match_count increments unless already all-ones.
  - count_sat<=1 when the increment reaches all-ones; it stays set.
  - clr_count zeroes both.
  - If clr_count and hit occur in the same cycle, clr_count wins: result 0, the hit is not counted.
  - rst and pat_load have no additional effect on the counter beyond those stated above.
- FSM view (for documentation): states FILL(k), k=0..N-1; ARMED (fill=N, no match); MATCH (out=1).
  - Transitions are as defined by the equations above.
  - No other states; no unreachable-state recovery is needed beyond rst.

Test Plan:
- Overlap: N=4, PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 with en=1 every cycle -> out pulses 1 clock after bit 4 and after bit 7; match_count=2.
- Non-overlap: same stream with OVERLAP=0 -> single out pulse after bit 4; match_count=1. Then stream 1,0,1,1,1,0,1,1 from reset -> pulses after bits 4 and 8.
- en gaps: send 1,0,1,1 with en=0 for 3 cycles between each bit -> exactly one pulse, 1 clock after the final accepted bit. out=0 during all gap cycles.
- Runtime pattern: after 1,0,1 pulse pat_load with pat_in=0110, then stream 0,1,1,0 -> no stale match from the old history; pulse after the 4th bit. Original pattern 1011 no longer detected.
- Counter saturation: CNT_W=2, all-ones pattern 1111 overlapping, 8 consecutive 1s -> matches on bits 4..8; match_count sticks at 3; count_sat=1. Then clr_count -> both 0.
- Reset mid-operation: after 1,0,1 assert rst one cycle, then send 1 -> no pulse. All outputs 0 the clock after rst. Then 1,0,1,1 -> pulse.

Source files
------------

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial-sequence detector with runtime pattern reload,
// bit-valid qualifier, overlap/non-overlap modes and a saturating match counter.
module moore_seq_detector_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             clr_count,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  // fill counts 0..N, so it needs room for the value N itself
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]     pat_q,  pat_d;
  logic [N-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             sat_q,  sat_d;

  logic [N-1:0]     hist_n;
  logic [FW-1:0]    fill_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             acc_hit;

  assign hist_n  = {hist_q[N-2:0], in};
  assign fill_n  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
  assign hit     = (fill_n == FILL_FULL) && (hist_n == pat_q);
  // a hit only counts on an accepted bit; pat_load drops the bit
  assign acc_hit = en && !pat_load && hit;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // next-state: pattern/history/fill/match, then the counter
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d  = hist_n;
      match_d = hit;
      // non-overlap restarts the history count so a new match needs N fresh bits
      fill_d  = (hit && !OVERLAP) ? '0 : fill_n;
    end

    // clear beats a coincident hit
    if (clr_count) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (acc_hit && !(&cnt_q)) begin
      cnt_d = cnt_inc;
      if (&cnt_inc) sat_d = 1'b1;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign out         = match_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Bench for moore_seq_detector_param: three instances (overlap 1011,
// non-overlap 1011, overlap 1111 with a 2-bit counter), table vectors plus
// hand-written sequences, expected values queued at drive time.
module tb_moore_seq_detector_param;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0]      rst, en, in_b, pl, clr;
  logic [ND-1:0][3:0] pi;
  logic [ND-1:0]      out_w, sat_w;
  logic [7:0]         cnt0, cnt1;
  logic [1:0]         cnt2;
  logic [ND-1:0][7:0] cnt;

  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;
  assign cnt[2] = {6'b0, cnt2};

  moore_seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst[0]), .en(en[0]), .in(in_b[0]), .pat_load(pl[0]), .pat_in(pi[0]),
    .clr_count(clr[0]), .out(out_w[0]), .match_count(cnt0), .count_sat(sat_w[0]));

  moore_seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst[1]), .en(en[1]), .in(in_b[1]), .pat_load(pl[1]), .pat_in(pi[1]),
    .clr_count(clr[1]), .out(out_w[1]), .match_count(cnt1), .count_sat(sat_w[1]));

  moore_seq_detector_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst[2]), .en(en[2]), .in(in_b[2]), .pat_load(pl[2]), .pat_in(pi[2]),
    .clr_count(clr[2]), .out(out_w[2]), .match_count(cnt2), .count_sat(sat_w[2]));

  typedef struct {
    logic       rst, en, in, pl;
    logic [3:0] pi;
    logic       clr;
    logic       eo;
    logic [7:0] ec;
    logic       es;
  } vec_t;

  typedef struct {
    int         d;
    logic       eo;
    logic [7:0] ec;
    logic       es;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, want);
    end
  endtask

  // drive one cycle on DUT d, queue its expectation, compare after the edge
  task automatic apply(input int d, input vec_t v);
    exp_t e;
    rst = '0; en = '0; in_b = '0; pl = '0; clr = '0; pi = '0;
    rst[d] = v.rst; en[d] = v.en; in_b[d] = v.in; pl[d] = v.pl; pi[d] = v.pi; clr[d] = v.clr;
    exp_q.push_back('{d: d, eo: v.eo, ec: v.ec, es: v.es});
    @(posedge clk);
    #1;
    step_no++;
    e = exp_q.pop_front();
    chk($sformatf("out[%0d]", e.d), {7'b0, out_w[e.d]}, {7'b0, e.eo});
    chk($sformatf("count[%0d]", e.d), cnt[e.d], e.ec);
    chk($sformatf("sat[%0d]", e.d), {7'b0, sat_w[e.d]}, {7'b0, e.es});
  endtask

  task automatic go(input int d, input logic r, input logic e_, input logic b, input logic l,
                    input logic [3:0] p, input logic c, input logic eo, input logic [7:0] ec,
                    input logic es);
    vec_t v;
    v = '{rst: r, en: e_, in: b, pl: l, pi: p, clr: c, eo: eo, ec: ec, es: es};
    apply(d, v);
  endtask

  task automatic bit_(input int d, input logic b, input logic eo, input logic [7:0] ec, input logic es);
    go(d, 1'b0, 1'b1, b, 1'b0, 4'h0, 1'b0, eo, ec, es);
  endtask

  task automatic idle(input int d, input logic [7:0] ec, input logic es);
    go(d, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ec, es);
  endtask

  task automatic rs(input int d);
    go(d, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  vec_t tbl[7];

  initial begin
    rst = '1; en = '0; in_b = '0; pl = '0; clr = '0; pi = '0;

    // overlap stream 1,0,1,1,0,1,1: pulses after bits 4 and 7
    tbl[0] = '{rst:0, en:1, in:1, pl:0, pi:0, clr:0, eo:0, ec:0, es:0};
    tbl[1] = '{rst:0, en:1, in:0, pl:0, pi:0, clr:0, eo:0, ec:0, es:0};
    tbl[2] = '{rst:0, en:1, in:1, pl:0, pi:0, clr:0, eo:0, ec:0, es:0};
    tbl[3] = '{rst:0, en:1, in:1, pl:0, pi:0, clr:0, eo:1, ec:1, es:0};
    tbl[4] = '{rst:0, en:1, in:0, pl:0, pi:0, clr:0, eo:0, ec:1, es:0};
    tbl[5] = '{rst:0, en:1, in:1, pl:0, pi:0, clr:0, eo:0, ec:1, es:0};
    tbl[6] = '{rst:0, en:1, in:1, pl:0, pi:0, clr:0, eo:1, ec:2, es:0};

    for (int d = 0; d < ND; d++) rs(d);
    for (int i = 0; i < 7; i++) apply(0, tbl[i]);

    // en gaps on DUT0: 1,0,1,1 with three idle cycles between bits
    rs(0);
    bit_(0, 1, 0, 0, 0); repeat (3) idle(0, 0, 0);
    bit_(0, 0, 0, 0, 0); repeat (3) idle(0, 0, 0);
    bit_(0, 1, 0, 0, 0); repeat (3) idle(0, 0, 0);
    bit_(0, 1, 1, 1, 0);
    idle(0, 1, 0);

    // runtime reload after a partial 1,0,1; the bit in the load cycle is dropped
    bit_(0, 1, 0, 1, 0); bit_(0, 0, 0, 1, 0); bit_(0, 1, 0, 1, 0);
    go(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 8'd1, 1'b0);
    bit_(0, 0, 0, 1, 0); bit_(0, 1, 0, 1, 0); bit_(0, 1, 0, 1, 0);
    bit_(0, 0, 1, 2, 0);
    // old pattern no longer detected
    bit_(0, 1, 0, 2, 0); bit_(0, 0, 0, 2, 0); bit_(0, 1, 0, 2, 0); bit_(0, 1, 0, 2, 0);
    // history now 1011; a 0 completes 0110 while clr_count is high: clear wins
    go(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 8'd0, 1'b0);

    // reset mid-sequence restores 1011 and discards history
    bit_(0, 1, 0, 0, 0); bit_(0, 0, 0, 0, 0); bit_(0, 1, 0, 0, 0);
    rs(0);
    bit_(0, 1, 0, 0, 0);
    bit_(0, 1, 0, 0, 0); bit_(0, 0, 0, 0, 0); bit_(0, 1, 0, 0, 0);
    bit_(0, 1, 1, 1, 0);

    // non-overlap: same stream gives a single pulse
    bit_(1, 1, 0, 0, 0); bit_(1, 0, 0, 0, 0); bit_(1, 1, 0, 0, 0); bit_(1, 1, 1, 1, 0);
    bit_(1, 0, 0, 1, 0); bit_(1, 1, 0, 1, 0); bit_(1, 1, 0, 1, 0);
    rs(1);
    bit_(1, 1, 0, 0, 0); bit_(1, 0, 0, 0, 0); bit_(1, 1, 0, 0, 0); bit_(1, 1, 1, 1, 0);
    bit_(1, 1, 0, 1, 0); bit_(1, 0, 0, 1, 0); bit_(1, 1, 0, 1, 0); bit_(1, 1, 1, 2, 0);
    idle(1, 2, 0);

    // saturation: 1111 overlapping, 2-bit counter, eight 1s
    bit_(2, 1, 0, 0, 0); bit_(2, 1, 0, 0, 0); bit_(2, 1, 0, 0, 0);
    bit_(2, 1, 1, 1, 0); bit_(2, 1, 1, 2, 0); bit_(2, 1, 1, 3, 1);
    bit_(2, 1, 1, 3, 1); bit_(2, 1, 1, 3, 1);
    go(2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 8'd0, 1'b0);
    // coincident hit and clear: pulse still seen, count stays 0
    go(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 8'd0, 1'b0);
    bit_(2, 1, 1, 1, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
